// File: rtl/router_pkt_rx.sv
// Receiver for one router output port: drains the port FIFO, parses
// {len, addr} header + payload + parity byte, and streams the payload out with status.
module router_pkt_rx #(
    parameter logic [1:0]  PORT_ID     = 2'd2,
    parameter int unsigned START_DELAY = 2,
    parameter int unsigned TIMEOUT     = 32
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       valid_out,
    input  logic [7:0] data_out,
    output logic       read_enb,
    input  logic       hold,
    output logic [7:0] pkt_data,
    output logic       pkt_data_vld,
    output logic       pkt_sop,
    output logic       pkt_eop,
    output logic [5:0] pkt_len,
    output logic [1:0] dest_addr,
    output logic       pkt_done,
    output logic       parity_err,
    output logic       addr_err,
    output logic       trunc_err,
    output logic       rx_busy,
    output logic [7:0] pkt_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_HDR_RD  = 3'd2,
        S_HDR_CAP = 3'd3,
        S_STREAM  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [3:0] DLY_LAST = 4'(START_DELAY);
    localparam logic [7:0] TMO      = 8'(TIMEOUT);

    function automatic logic [7:0] parity_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t     state_q;
    logic [3:0] dly_q;
    logic [6:0] reads_left_q;
    logic [6:0] recv_left_q;
    logic [7:0] stall_q;
    logic [7:0] acc_q;
    logic       rd_d1_q;
    logic       first_q;
    logic [7:0] pkt_data_q;
    logic       pkt_data_vld_q;
    logic       pkt_sop_q;
    logic       pkt_eop_q;
    logic [5:0] pkt_len_q;
    logic [1:0] dest_addr_q;
    logic       pkt_done_q;
    logic       parity_err_q;
    logic       addr_err_q;
    logic       trunc_err_q;
    logic       rx_busy_q;
    logic [7:0] pkt_count_q;

    logic       read_s;
    logic [7:0] stall_d;

    // Read strobe must follow valid_out/hold in the same cycle so the FIFO is never over-read.
    always_comb begin
        read_s = 1'b0;
        case (state_q)
            S_HDR_RD: read_s = valid_out;
            S_STREAM: read_s = valid_out & ~hold & (reads_left_q != 7'd0);
            default:  read_s = 1'b0;
        endcase
    end

    // Stall counter next value: cleared by a read, counts only genuine starvation.
    always_comb begin
        if (read_s) begin
            stall_d = 8'd0;
        end else if (!valid_out && !hold) begin
            stall_d = stall_q + 8'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Receive FSM with registered payload and status outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            dly_q          <= 4'd0;
            reads_left_q   <= 7'd0;
            recv_left_q    <= 7'd0;
            stall_q        <= 8'd0;
            acc_q          <= 8'd0;
            rd_d1_q        <= 1'b0;
            first_q        <= 1'b0;
            pkt_data_q     <= 8'd0;
            pkt_data_vld_q <= 1'b0;
            pkt_sop_q      <= 1'b0;
            pkt_eop_q      <= 1'b0;
            pkt_len_q      <= 6'd0;
            dest_addr_q    <= 2'd0;
            pkt_done_q     <= 1'b0;
            parity_err_q   <= 1'b0;
            addr_err_q     <= 1'b0;
            trunc_err_q    <= 1'b0;
            rx_busy_q      <= 1'b0;
            pkt_count_q    <= 8'd0;
        end else begin
            pkt_data_vld_q <= 1'b0;
            pkt_sop_q      <= 1'b0;
            pkt_eop_q      <= 1'b0;
            pkt_done_q     <= 1'b0;
            rd_d1_q        <= read_s;
            case (state_q)
                S_IDLE: begin
                    if (valid_out) begin
                        state_q   <= S_WAIT;
                        dly_q     <= 4'd0;
                        rx_busy_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (dly_q == DLY_LAST) begin
                        state_q <= S_HDR_RD;
                    end else begin
                        dly_q <= dly_q + 4'd1;
                    end
                end
                S_HDR_RD: begin
                    if (valid_out) begin
                        state_q <= S_HDR_CAP;
                    end
                end
                S_HDR_CAP: begin
                    pkt_len_q    <= data_out[7:2];
                    dest_addr_q  <= data_out[1:0];
                    acc_q        <= data_out;
                    reads_left_q <= {1'b0, data_out[7:2]} + 7'd1;
                    recv_left_q  <= {1'b0, data_out[7:2]} + 7'd1;
                    first_q      <= 1'b1;
                    stall_q      <= 8'd0;
                    state_q      <= S_STREAM;
                end
                S_STREAM: begin
                    stall_q <= stall_d;
                    if (read_s) begin
                        reads_left_q <= reads_left_q - 7'd1;
                    end
                    if (rd_d1_q && (recv_left_q > 7'd1)) begin
                        acc_q          <= parity_step(acc_q, data_out);
                        pkt_data_q     <= data_out;
                        pkt_data_vld_q <= 1'b1;
                        pkt_sop_q      <= first_q;
                        pkt_eop_q      <= (recv_left_q == 7'd2);
                        first_q        <= 1'b0;
                        recv_left_q    <= recv_left_q - 7'd1;
                    end
                    // A completing parity byte wins over a coincident timeout.
                    if (rd_d1_q && (recv_left_q == 7'd1)) begin
                        recv_left_q  <= 7'd0;
                        parity_err_q <= (acc_q != data_out);
                        addr_err_q   <= (dest_addr_q != PORT_ID);
                        trunc_err_q  <= 1'b0;
                        pkt_done_q   <= 1'b1;
                        pkt_count_q  <= pkt_count_q + 8'd1;
                        state_q      <= S_DONE;
                    end else if (stall_d == TMO) begin
                        parity_err_q <= 1'b0;
                        addr_err_q   <= (dest_addr_q != PORT_ID);
                        trunc_err_q  <= 1'b1;
                        pkt_done_q   <= 1'b1;
                        pkt_count_q  <= pkt_count_q + 8'd1;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    rx_busy_q <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign read_enb     = read_s;
    assign pkt_data     = pkt_data_q;
    assign pkt_data_vld = pkt_data_vld_q;
    assign pkt_sop      = pkt_sop_q;
    assign pkt_eop      = pkt_eop_q;
    assign pkt_len      = pkt_len_q;
    assign dest_addr    = dest_addr_q;
    assign pkt_done     = pkt_done_q;
    assign parity_err   = parity_err_q;
    assign addr_err     = addr_err_q;
    assign trunc_err    = trunc_err_q;
    assign rx_busy      = rx_busy_q;
    assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_router_pkt_rx.sv
// Scoreboard bench for router_pkt_rx: a behavioural FIFO feeds the receiver,
// expected bytes/status are queued at stimulus time and checked by a monitor.
module tb_router_pkt_rx;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       valid_out = 1'b0;
    logic [7:0] data_out = 8'd0;
    logic       hold = 1'b0;
    logic       read_enb;
    logic [7:0] pkt_data;
    logic       pkt_data_vld, pkt_sop, pkt_eop, pkt_done;
    logic [5:0] pkt_len;
    logic [1:0] dest_addr;
    logic       parity_err, addr_err, trunc_err, rx_busy;
    logic [7:0] pkt_count;

    router_pkt_rx #(.PORT_ID(2'd2), .START_DELAY(2), .TIMEOUT(32)) dut (
        .clock(clock), .resetn(resetn), .valid_out(valid_out), .data_out(data_out),
        .read_enb(read_enb), .hold(hold), .pkt_data(pkt_data), .pkt_data_vld(pkt_data_vld),
        .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_len(pkt_len), .dest_addr(dest_addr),
        .pkt_done(pkt_done), .parity_err(parity_err), .addr_err(addr_err),
        .trunc_err(trunc_err), .rx_busy(rx_busy), .pkt_count(pkt_count)
    );

    always #5 clock = ~clock;

    logic [7:0]  fifo_q[$];
    logic [9:0]  exp_b_q[$];   // {sop, eop, data}
    logic [18:0] exp_d_q[$];   // {len, dest, perr, aerr, terr, count}
    int          n_cmp = 0;
    int          n_err = 0;
    int          rd_total = 0;
    int          done_seen = 0;
    int          vld_seen = 0;
    logic [7:0]  exp_count = 8'd0;

    // Behavioural router FIFO: one-cycle read latency, valid_out = not empty.
    initial begin
        logic rd_seen;
        forever begin
            @(negedge clock);
            rd_seen = read_enb;
            if (read_enb) rd_total++;
            @(posedge clock);
            #1;
            if (rd_seen && fifo_q.size() > 0) data_out = fifo_q.pop_front();
            valid_out = (fifo_q.size() != 0);
        end
    end

    // Monitor: compares every delivered byte and every pkt_done against the queues.
    initial begin
        logic [9:0]  eb;
        logic [18:0] ed;
        logic [18:0] ad;
        forever begin
            @(negedge clock);
            if (pkt_data_vld) begin
                vld_seen++;
                n_cmp++;
                if (exp_b_q.size() == 0) begin
                    n_err++;
                    $display("FAIL byte_unexpected: got sop=%0b eop=%0b data=%h, expected no byte",
                             pkt_sop, pkt_eop, pkt_data);
                end else begin
                    eb = exp_b_q.pop_front();
                    if ({pkt_sop, pkt_eop, pkt_data} !== eb) begin
                        n_err++;
                        $display("FAIL byte: got sop=%0b eop=%0b data=%h, expected sop=%0b eop=%0b data=%h",
                                 pkt_sop, pkt_eop, pkt_data, eb[9], eb[8], eb[7:0]);
                    end
                end
            end
            if (pkt_done) begin
                done_seen++;
                n_cmp++;
                ad = {pkt_len, dest_addr, parity_err, addr_err, trunc_err, pkt_count};
                if (exp_d_q.size() == 0) begin
                    n_err++;
                    $display("FAIL done_unexpected: got status %h, expected no pkt_done", ad);
                end else begin
                    ed = exp_d_q.pop_front();
                    if (ad !== ed) begin
                        n_err++;
                        $display("FAIL done_status: got len=%0d dest=%0d perr=%0b aerr=%0b terr=%0b cnt=%0d, expected len=%0d dest=%0d perr=%0b aerr=%0b terr=%0b cnt=%0d",
                                 ad[18:13], ad[12:11], ad[10], ad[9], ad[8], ad[7:0],
                                 ed[18:13], ed[12:11], ed[10], ed[9], ed[8], ed[7:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Pushes header, n_pay payload bytes (0,1,2..) and optionally parity; queues expectations.
    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] par, input int n_pay,
                            input logic send_par, input logic perr, input logic aerr, input logic terr);
        logic [5:0] len;
        len = hdr[7:2];
        fifo_q.push_back(hdr);
        for (int i = 0; i < n_pay; i++) begin
            fifo_q.push_back(8'(i));
            exp_b_q.push_back({(i == 0), (!terr && (i == int'(len) - 1)), 8'(i)});
        end
        if (send_par) fifo_q.push_back(par);
        exp_count = exp_count + 8'd1;
        exp_d_q.push_back({len, hdr[1:0], perr, aerr, terr, exp_count});
    endtask

    task automatic wait_done(input int budget, input string tag);
        int start;
        int k;
        start = done_seen;
        k = 0;
        while (done_seen == start && k < budget) begin
            @(posedge clock);
            #2;
            k++;
        end
        n_cmp++;
        if (done_seen == start) begin
            n_err++;
            $display("FAIL %s_done_wait: got no pkt_done in %0d cycles, expected one", tag, budget);
        end
        repeat (3) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic outputs_zero(input string tag);
        check(tag, {pkt_data, pkt_data_vld, pkt_sop, pkt_eop, pkt_len, dest_addr, pkt_done,
                    parity_err, addr_err, trunc_err, rx_busy, pkt_count, read_enb}, 32'd0);
    endtask

    initial begin
        int base;
        int vbase;
        int k;
        #2;
        outputs_zero("reset_outputs");
        repeat (3) @(posedge clock);
        #2;
        resetn = 1'b1;
        @(posedge clock);
        #2;
        check("idle_not_busy", rx_busy, 0);

        // Good packet: len 16, addr 2, payload 0..15, parity 0x42
        base = rd_total;
        send_pkt(8'h42, 8'h42, 16, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(200, "good");
        check("good_read_count", rd_total - base, 18);
        check("good_back_idle", rx_busy, 0);

        // Bad parity 0x43
        send_pkt(8'h42, 8'h43, 16, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_done(200, "parity");

        // len 0
        base = rd_total;
        vbase = vld_seen;
        send_pkt(8'h02, 8'h02, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(200, "len0");
        check("len0_read_count", rd_total - base, 2);
        check("len0_no_bytes", vld_seen - vbase, 0);

        // Wrong address 1: still fully delivered
        send_pkt(8'h41, 8'h41, 16, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_done(200, "addr");

        // Hold for 3 cycles after the 5th payload read
        base = rd_total;
        send_pkt(8'h42, 8'h42, 16, 1'b1, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (rd_total < base + 6 && k < 100) begin
            @(posedge clock);
            #2;
            k++;
        end
        check("hold_reach_5th", (rd_total >= base + 6), 1);
        hold = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("hold_read_low", read_enb, 0);
            @(posedge clock);
            #2;
        end
        hold = 1'b0;
        wait_done(200, "hold");
        check("hold_read_count", rd_total - base, 18);

        // Source stops after 5 payload bytes: timeout abort
        send_pkt(8'h42, 8'h00, 5, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done(200, "timeout");
        check("timeout_back_idle", rx_busy, 0);
        send_pkt(8'h42, 8'h42, 16, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(200, "after_timeout");

        // Reset mid-payload
        vbase = vld_seen;
        send_pkt(8'h42, 8'h42, 16, 1'b1, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (vld_seen < vbase + 4 && k < 100) begin
            @(posedge clock);
            #2;
            k++;
        end
        check("reset_reach_payload", (vld_seen >= vbase + 4), 1);
        resetn = 1'b0;
        fifo_q.delete();
        exp_b_q.delete();
        exp_d_q.delete();
        exp_count = 8'd0;
        #1;
        outputs_zero("midpkt_reset_outputs");
        repeat (3) @(posedge clock);
        #2;
        resetn = 1'b1;
        base = done_seen;
        repeat (20) @(posedge clock);
        #2;
        check("reset_no_done", done_seen - base, 0);
        check("reset_count_zero", pkt_count, 0);
        send_pkt(8'h42, 8'h42, 16, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(200, "after_reset");

        check("bytes_left", exp_b_q.size(), 0);
        check("done_left", exp_d_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule
